// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with first-word-fall-through read data,
// occupancy count, programmable almost flags and sticky error flags.
module fifo_sync_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = 12,
  parameter int AE_LVL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        w_data,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr_err,
  output logic [DATA_W-1:0]        r_data,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LVL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LVL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [CNT_W-1:0]  count_next;
  logic              push_ok;
  logic              pop_ok;

  // Handshake: a push is accepted when push=1 and full=0, a pop when pop=1 and
  // empty=0, both judged on the registered flags of the current cycle. A
  // rejected request has no effect besides raising its sticky error flag.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok) count_next = count + CNT_W'(1);
    else if (pop_ok && !push_ok) count_next = count - CNT_W'(1);
  end

  assign r_data = mem[rptr];

  // Storage carries no reset; contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wptr] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + ADDR_W'(1);
      if (pop_ok)  rptr <= rptr + ADDR_W'(1);
      count        <= count_next;
      full         <= (count_next == DEPTH_C);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= AF_C);
      almost_empty <= (count_next <= AE_C);
      // A new error in the same cycle as clr_err keeps the flag set.
      if (push && full)   overflow  <= 1'b1;
      else if (clr_err)   overflow  <= 1'b0;
      if (pop && empty)   underflow <= 1'b1;
      else if (clr_err)   underflow <= 1'b0;
    end
  end

endmodule
